// File: rtl/pool_ctrl_pkg.sv
// Shared definitions for the pooling sequencer: FSM state encoding,
// legal pool-window constants and the lane-slice width helper.
package pool_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam logic [31:0] WIN_1 = 32'd1;
  localparam logic [31:0] WIN_2 = 32'd2;
  localparam logic [31:0] WIN_4 = 32'd4;

  // True for the window sizes the pool unit supports.
  function automatic logic window_is_legal(input logic [31:0] w);
    return (w == WIN_1) || (w == WIN_2) || (w == WIN_4);
  endfunction

  // Lanes kept per pooled row (DESIGN_SIZE / w) for a legal window.
  // Any other window falls back to the full row; such jobs never pack data.
  function automatic int slice_lanes(input int lanes, input logic [31:0] w);
    int r;
    case (w)
      WIN_1:   r = lanes;
      WIN_2:   r = lanes >>> 1;
      WIN_4:   r = lanes >>> 2;
      default: r = lanes;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pool_ctrl_pack.sv
// Packs reduced rows from the pool unit into full-width destination words.
// Slot s holds lanes [0,L) of one pooled row, L = DESIGN_SIZE/w; a word is
// issued when the last slot fills or on the final row of the job, with any
// unfilled slots left at zero.
module pool_pack
  import pool_ctrl_pkg::*;
#(
  parameter int DESIGN_SIZE   = 8,
  parameter int DWIDTH        = 8,
  parameter int MAX_BITS_POOL = 3,
  parameter int ROWS_W        = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear_i,
  input  logic                          active_i,
  input  logic [MAX_BITS_POOL-1:0]      win_i,
  input  logic [ROWS_W-1:0]             rows_i,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] pool_out_data_i,
  input  logic                          pool_out_valid_i,
  output logic                          dst_wr_en_o,
  output logic [DESIGN_SIZE*DWIDTH-1:0] dst_wr_data_o,
  output logic                          dst_last_o
);

  localparam int DW = DESIGN_SIZE * DWIDTH;
  localparam logic [MAX_BITS_POOL-1:0] SLOT_ONE = MAX_BITS_POOL'(1);
  localparam logic [ROWS_W-1:0]        ROW_ONE  = ROWS_W'(1);

  logic [MAX_BITS_POOL-1:0] slot_q, slot_d;
  logic [ROWS_W-1:0]        rows_q, rows_d;
  logic [DW-1:0]            word_q, word_d;
  logic                     wr_en_q, wr_en_d;
  logic [DW-1:0]            wr_data_q, wr_data_d;
  logic                     wr_last_q, wr_last_d;

  int            lanes_s;
  int            slot_lo_s;
  logic [DW-1:0] merged_s;
  logic          last_row_s;
  logic          last_slot_s;

  // Place the incoming row slice into the current slot of the word in progress.
  always_comb begin
    lanes_s   = slice_lanes(DESIGN_SIZE, 32'(win_i));
    slot_lo_s = int'(slot_q) * lanes_s;
    merged_s  = word_q;
    for (int j = 0; j < DESIGN_SIZE; j++) begin
      for (int l = 0; l < DESIGN_SIZE; l++) begin
        merged_s[j*DWIDTH +: DWIDTH] = ((l < lanes_s) && (j == slot_lo_s + l))
                                       ? pool_out_data_i[l*DWIDTH +: DWIDTH]
                                       : merged_s[j*DWIDTH +: DWIDTH];
      end
    end
    last_row_s  = (rows_q == (rows_i - ROW_ONE));
    last_slot_s = (slot_q == (win_i - SLOT_ONE));
  end

  // Slot/row bookkeeping and issue decision for the destination write.
  always_comb begin
    slot_d    = slot_q;
    rows_d    = rows_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_last_d = 1'b0;
    if (clear_i) begin
      slot_d = {MAX_BITS_POOL{1'b0}};
      rows_d = {ROWS_W{1'b0}};
      word_d = {DW{1'b0}};
    end else if (active_i && pool_out_valid_i) begin
      rows_d = rows_q + ROW_ONE;
      if (last_slot_s || last_row_s) begin
        wr_en_d   = 1'b1;
        wr_data_d = merged_s;
        wr_last_d = last_row_s;
        slot_d    = {MAX_BITS_POOL{1'b0}};
        word_d    = {DW{1'b0}};
      end else begin
        slot_d = slot_q + SLOT_ONE;
        word_d = merged_s;
      end
    end else begin
      slot_d = slot_q;
    end
  end

  // Packing state and the registered destination write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= {MAX_BITS_POOL{1'b0}};
      rows_q    <= {ROWS_W{1'b0}};
      word_q    <= {DW{1'b0}};
      wr_en_q   <= 1'b0;
      wr_data_q <= {DW{1'b0}};
      wr_last_q <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      rows_q    <= rows_d;
      word_q    <= word_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_last_q <= wr_last_d;
    end
  end

  assign dst_wr_en_o   = wr_en_q;
  assign dst_wr_data_o = wr_data_q;
  assign dst_last_o    = wr_en_q & wr_last_q;

endmodule

// File: rtl/pool_ctrl.sv
// Pooling sequencer: streams N source rows through the pool unit and writes
// the packed results to the destination buffer, then pulses done.
// Optional feature: define POOL_CTRL_PERF_CNT_EN to build the 32-bit
// busy-cycle counter on perf_cycles; otherwise perf_cycles is tied to 0.
// done/err are registered off the FINISH state, so they appear one cycle
// after FINISH, while the FSM is already back in IDLE; start is ignored in
// that cycle so a new job's first read trails done by at least 2 cycles.
module pool_ctrl
  import pool_ctrl_pkg::*;
#(
  parameter int DESIGN_SIZE   = 8,
  parameter int DWIDTH        = 8,
  parameter int ADDR_W        = 10,
  parameter int MAX_BITS_POOL = 3,
  parameter int ROWS_W        = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MAX_BITS_POOL-1:0]      pool_window_size,
  input  logic [ROWS_W-1:0]             num_rows,
  input  logic [ADDR_W-1:0]             src_base_addr,
  input  logic [ADDR_W-1:0]             dst_base_addr,
  output logic                          src_rd_en,
  output logic [ADDR_W-1:0]             src_addr,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] src_rd_data,
  output logic                          pool_enable,
  output logic [MAX_BITS_POOL-1:0]      pool_window,
  output logic [DESIGN_SIZE*DWIDTH-1:0] pool_in_data,
  output logic                          pool_in_valid,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] pool_out_data,
  input  logic                          pool_out_valid,
  output logic                          dst_wr_en,
  output logic [ADDR_W-1:0]             dst_addr,
  output logic [DESIGN_SIZE*DWIDTH-1:0] dst_wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [31:0]                   perf_cycles
);

  localparam int DW = DESIGN_SIZE * DWIDTH;
  localparam logic [ROWS_W-1:0] ROW_ONE  = ROWS_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e                   state_q, state_d;
  logic [MAX_BITS_POOL-1:0] win_q;
  logic [ROWS_W-1:0]        rows_q;
  logic [ROWS_W-1:0]        rd_cnt_q;
  logic [ADDR_W-1:0]        src_addr_q;
  logic [ADDR_W-1:0]        dst_addr_q;
  logic                     rd_pend_q;
  logic                     illegal_q;
  logic                     done_q;
  logic                     err_q;

  logic accept_s;
  logic legal_s;
  logic busy_s;
  logic wr_en_s;
  logic wr_last_s;

  assign accept_s = (state_q == ST_IDLE) && start && !done_q;
  assign legal_s  = window_is_legal(32'(pool_window_size));
  assign busy_s   = (state_q != ST_IDLE);

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = (legal_s && (num_rows != {ROWS_W{1'b0}})) ? ST_READ : ST_FINISH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_cnt_q == ROW_ONE) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (wr_last_s) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Job configuration latch, address counters and registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q      <= {MAX_BITS_POOL{1'b0}};
      rows_q     <= {ROWS_W{1'b0}};
      rd_cnt_q   <= {ROWS_W{1'b0}};
      src_addr_q <= {ADDR_W{1'b0}};
      dst_addr_q <= {ADDR_W{1'b0}};
      illegal_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept_s) begin
        win_q      <= pool_window_size;
        rows_q     <= num_rows;
        rd_cnt_q   <= num_rows;
        src_addr_q <= src_base_addr;
        dst_addr_q <= dst_base_addr;
        illegal_q  <= !legal_s;
      end else begin
        if (state_q == ST_READ) begin
          rd_cnt_q   <= rd_cnt_q - ROW_ONE;
          src_addr_q <= src_addr_q + ADDR_ONE;
        end
        if (wr_en_s) begin
          dst_addr_q <= dst_addr_q + ADDR_ONE;
        end
      end
      rd_pend_q <= (state_q == ST_READ);
      done_q    <= (state_q == ST_FINISH);
      err_q     <= (state_q == ST_FINISH) && illegal_q;
    end
  end

  pool_pack #(
    .DESIGN_SIZE   (DESIGN_SIZE),
    .DWIDTH        (DWIDTH),
    .MAX_BITS_POOL (MAX_BITS_POOL),
    .ROWS_W        (ROWS_W)
  ) u_pack (
    .clk              (clk),
    .reset            (reset),
    .clear_i          (accept_s),
    .active_i         (busy_s),
    .win_i            (win_q),
    .rows_i           (rows_q),
    .pool_out_data_i  (pool_out_data),
    .pool_out_valid_i (pool_out_valid),
    .dst_wr_en_o      (wr_en_s),
    .dst_wr_data_o    (dst_wr_data),
    .dst_last_o       (wr_last_s)
  );

`ifdef POOL_CTRL_PERF_CNT_EN
  logic [31:0] perf_q;

  // Busy-cycle counter: cleared on accept, saturating, held between jobs.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= 32'd0;
    end else if (accept_s) begin
      perf_q <= 32'd0;
    end else if (busy_s && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end else begin
      perf_q <= perf_q;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

  assign src_rd_en     = (state_q == ST_READ);
  assign src_addr      = src_addr_q;
  assign pool_enable   = busy_s;
  assign pool_window   = win_q;
  assign pool_in_valid = rd_pend_q;
  // Pass-through of the read data, forced to zero outside the valid cycle.
  assign pool_in_data  = rd_pend_q ? src_rd_data : {DW{1'b0}};
  assign dst_wr_en     = wr_en_s;
  assign dst_addr      = dst_addr_q;
  assign busy          = busy_s;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_pool_ctrl.sv
// Self-checking bench for pool_ctrl: directed jobs from the test plan plus
// randomized jobs, compared against a cycle-schedule reference model.
module tb_pool_ctrl;

  localparam logic [63:0] KEY = 64'h5A5A_0F0F_3C3C_9696;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  pool_window_size = 3'd0;
  logic [7:0]  num_rows = 8'd0;
  logic [9:0]  src_base_addr = 10'd0;
  logic [9:0]  dst_base_addr = 10'd0;
  logic        src_rd_en;
  logic [9:0]  src_addr;
  logic [63:0] src_rd_data = 64'd0;
  logic        pool_enable;
  logic [2:0]  pool_window;
  logic [63:0] pool_in_data;
  logic        pool_in_valid;
  logic [63:0] pool_out_data = 64'd0;
  logic        pool_out_valid = 1'b0;
  logic        dst_wr_en;
  logic [9:0]  dst_addr;
  logic [63:0] dst_wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] perf_cycles;

  logic [63:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  pool_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .pool_window_size(pool_window_size), .num_rows(num_rows),
    .src_base_addr(src_base_addr), .dst_base_addr(dst_base_addr),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rd_data(src_rd_data),
    .pool_enable(pool_enable), .pool_window(pool_window),
    .pool_in_data(pool_in_data), .pool_in_valid(pool_in_valid),
    .pool_out_data(pool_out_data), .pool_out_valid(pool_out_valid),
    .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_wr_data(dst_wr_data),
    .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  // Source SRAM (1-cycle read, garbage when idle) and a 1-cycle pool unit.
  always @(posedge clk) begin
    src_rd_data    <= src_rd_en ? mem[src_addr] : {$urandom, $urandom};
    pool_out_valid <= pool_in_valid;
    pool_out_data  <= pool_in_data ^ KEY;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pooled(input int sb, input int row);
    return mem[(sb + row) % 1024] ^ KEY;
  endfunction

  // Destination word j: slot s carries lanes [0,8/w) of pooled row j*w+s.
  function automatic logic [63:0] exp_word(input int w, input int n, input int sb, input int j);
    logic [63:0] r;
    logic [63:0] p;
    int lanes;
    lanes = 8 / w;
    r = 64'd0;
    for (int s = 0; s < w; s++) begin
      if (j * w + s < n) begin
        p = pooled(sb, j * w + s);
        for (int l = 0; l < lanes; l++) r[(s * lanes + l) * 8 +: 8] = p[l * 8 +: 8];
      end
    end
    return r;
  endfunction

  task automatic run_job(input int w, input int n, input int sb, input int db,
                         input int inject_at, input int reset_at);
    bit legal;
    bit active;
    int done_i;
    int k;
    legal  = (w == 1) || (w == 2) || (w == 4);
    active = legal && (n > 0);
    done_i = active ? n + 5 : 2;
    @(negedge clk);
    pool_window_size = 3'(w);
    num_rows         = 8'(n);
    src_base_addr    = 10'(sb);
    dst_base_addr    = 10'(db);
    start            = 1'b1;
    for (int i = 1; i <= done_i + 1; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (reset_at != 0 && i == reset_at + 1) begin
        chk("rst_rd_en", 64'(src_rd_en), 64'd0);
        chk("rst_src_addr", 64'(src_addr), 64'd0);
        chk("rst_pool_en", 64'(pool_enable), 64'd0);
        chk("rst_pool_win", 64'(pool_window), 64'd0);
        chk("rst_pin_data", pool_in_data, 64'd0);
        chk("rst_pin_valid", 64'(pool_in_valid), 64'd0);
        chk("rst_wr_en", 64'(dst_wr_en), 64'd0);
        chk("rst_dst_addr", 64'(dst_addr), 64'd0);
        chk("rst_wr_data", dst_wr_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_perf", 64'(perf_cycles), 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          chk("abort_done", 64'(done), 64'd0);
          chk("abort_rd_en", 64'(src_rd_en), 64'd0);
          chk("abort_wr_en", 64'(dst_wr_en), 64'd0);
        end
        break;
      end
      if (i == 1) chk("pool_window", 64'(pool_window), 64'(w));
      chk($sformatf("busy[%0d]", i), 64'(busy), 64'(i < done_i));
      chk($sformatf("pool_en[%0d]", i), 64'(pool_enable), 64'(i < done_i));
      chk($sformatf("rd_en[%0d]", i), 64'(src_rd_en), 64'(active && i <= n));
      if (active && i <= n)
        chk($sformatf("src_addr[%0d]", i), 64'(src_addr), 64'((sb + i - 1) % 1024));
      chk($sformatf("pin_valid[%0d]", i), 64'(pool_in_valid), 64'(active && i >= 2 && i <= n + 1));
      if (active && i >= 2 && i <= n + 1)
        chk($sformatf("pin_data[%0d]", i), pool_in_data, mem[(sb + i - 2) % 1024]);
      k = i - 4;
      if (active && k >= 0 && k < n && (((k + 1) % w == 0) || k == n - 1)) begin
        chk($sformatf("wr_en[%0d]", i), 64'(dst_wr_en), 64'd1);
        chk($sformatf("dst_addr[%0d]", i), 64'(dst_addr), 64'((db + k / w) % 1024));
        chk($sformatf("wr_data[%0d]", i), dst_wr_data, exp_word(w, n, sb, k / w));
      end else begin
        chk($sformatf("wr_en[%0d]", i), 64'(dst_wr_en), 64'd0);
      end
      chk($sformatf("done[%0d]", i), 64'(done), 64'(i == done_i));
      chk($sformatf("err[%0d]", i), 64'(err), 64'(i == done_i && !legal));
`ifdef POOL_CTRL_PERF_CNT_EN
      if (i >= done_i) chk($sformatf("perf[%0d]", i), 64'(perf_cycles), 64'(done_i - 1));
`else
      chk($sformatf("perf[%0d]", i), 64'(perf_cycles), 64'd0);
`endif
      if (inject_at != 0 && i == inject_at) begin
        start            = 1'b1;
        pool_window_size = 3'd2;
        num_rows         = 8'd3;
        src_base_addr    = 10'h155;
      end else if (inject_at != 0 && i == inject_at + 1) begin
        start = 1'b0;
      end
      if (reset_at != 0 && i == reset_at) reset = 1'b1;
    end
  endtask

  initial begin
    int wl[8];
    for (int a = 0; a < 1024; a++) mem[a] = {$urandom, $urandom};
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_rd_en", 64'(src_rd_en), 64'd0);
    chk("reset_wr_en", 64'(dst_wr_en), 64'd0);
    chk("reset_wr_data", dst_wr_data, 64'd0);
    chk("reset_perf", 64'(perf_cycles), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_job(1, 4, 'h10, 'h20, 0, 0);
    run_job(2, 5, 'h40, 'h80, 0, 0);
    run_job(4, 4, 'h3FE, 'h3FF, 0, 0);
    run_job(3, 6, 'h11, 'h22, 0, 0);
    run_job(2, 0, 'h33, 'h44, 0, 0);
    run_job(1, 8, 'h100, 'h200, 2, 3);

    wl = '{1, 2, 4, 1, 2, 4, 3, 0};
    for (int r = 0; r < 30; r++) begin
      run_job(wl[$urandom_range(0, 7)], $urandom_range(0, 13),
              $urandom_range(0, 1023), $urandom_range(0, 1023), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
